// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS memory-access stage with req/ack data port, stall generation and MEM/WB register.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject word-misaligned accesses (adds misalign_err).
`default_nettype none

module mem_wb_stage #(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        timeout_err
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] C_LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_cnt_nxt;

  // Hold registers capture the access and its M-stage controls for the wait.
  logic [31:0] r_h_addr;
  logic [31:0] r_h_wdata;
  logic        r_h_we;
  logic        r_h_regwrite;
  logic        r_h_memtoreg;
  logic [4:0]  r_h_writereg;

  logic        r_regwrite_w;
  logic        r_memtoreg_w;
  logic [31:0] r_readdata_w;
  logic [31:0] r_aluout_w;
  logic [4:0]  r_writereg_w;
  logic        r_timeout;

  logic        w_memop_raw;
  logic        w_misalign;
  logic        w_memop;
  logic        w_req;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_stall;
  logic        w_latch;
  logic        w_timeout;
  logic        w_bubble;

  logic        w_regwrite_n;
  logic        w_memtoreg_n;
  logic [31:0] w_readdata_n;
  logic [31:0] w_aluout_n;
  logic [4:0]  w_writereg_n;

  assign w_memop_raw = MemWriteM | MemtoRegM;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_memop_raw & (|ALUOutM[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_memop = w_memop_raw & ~w_misalign;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_req        = 1'b0;
    w_we         = MemWriteM;
    w_addr       = ALUOutM;
    w_wdata      = WriteDataM;
    w_stall      = 1'b0;
    w_latch      = 1'b0;
    w_timeout    = 1'b0;
    w_bubble     = 1'b0;
    w_regwrite_n = RegWriteM;
    w_memtoreg_n = MemtoRegM;
    w_readdata_n = 32'd0;
    w_aluout_n   = ALUOutM;
    w_writereg_n = WriteRegM;

    case (r_state)
      S_IDLE: begin
        w_req = w_memop;
        if (w_memop) begin
          if (dmem_ack) begin
            w_regwrite_n = RegWriteM & ~MemWriteM;
            w_readdata_n = MemWriteM ? 32'd0 : dmem_rdata;
          end else begin
            w_stall     = 1'b1;
            w_latch     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT;
            w_bubble    = 1'b1;
          end
        end else if (w_misalign) begin
          w_bubble = 1'b1;
        end
      end

      S_WAIT: begin
        w_req     = 1'b1;
        w_we      = r_h_we;
        w_addr    = r_h_addr;
        w_wdata   = r_h_wdata;
        w_cnt_nxt = r_cnt + WAIT_W'(1);
        if (dmem_ack) begin
          w_state_nxt  = S_IDLE;
          w_regwrite_n = r_h_regwrite & ~r_h_we;
          w_memtoreg_n = r_h_memtoreg;
          w_readdata_n = r_h_we ? 32'd0 : dmem_rdata;
          w_aluout_n   = r_h_addr;
          w_writereg_n = r_h_writereg;
        end else if (r_cnt == C_LAST_WAIT) begin
          // Abort: release the pipeline and let the stuck instruction fall out as a bubble.
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
          w_bubble    = 1'b1;
        end else begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_bubble    = 1'b1;
      end
    endcase

    if (w_bubble) begin
      w_regwrite_n = 1'b0;
      w_memtoreg_n = 1'b0;
      w_readdata_n = 32'd0;
      w_aluout_n   = 32'd0;
      w_writereg_n = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_addr     <= 32'd0;
      r_h_wdata    <= 32'd0;
      r_h_we       <= 1'b0;
      r_h_regwrite <= 1'b0;
      r_h_memtoreg <= 1'b0;
      r_h_writereg <= 5'd0;
    end else if (w_latch) begin
      r_h_addr     <= ALUOutM;
      r_h_wdata    <= WriteDataM;
      r_h_we       <= MemWriteM;
      r_h_regwrite <= RegWriteM;
      r_h_memtoreg <= MemtoRegM;
      r_h_writereg <= WriteRegM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
      r_readdata_w <= 32'd0;
      r_aluout_w   <= 32'd0;
      r_writereg_w <= 5'd0;
      r_timeout    <= 1'b0;
    end else begin
      r_regwrite_w <= w_regwrite_n;
      r_memtoreg_w <= w_memtoreg_n;
      r_readdata_w <= w_readdata_n;
      r_aluout_w   <= w_aluout_n;
      r_writereg_w <= w_writereg_n;
      r_timeout    <= w_timeout;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (r_state == S_IDLE) & w_misalign;
    end
  end

  assign misalign_err = r_misalign;
`endif

  // Request and stall are combinational, so gate them with reset to drop them immediately.
  assign dmem_req    = w_req & rst_n;
  assign StallM      = w_stall & rst_n;
  assign dmem_we     = w_we;
  assign dmem_addr   = w_addr;
  assign dmem_wdata  = w_wdata;
  assign RegWriteW   = r_regwrite_w;
  assign MemtoRegW   = r_memtoreg_w;
  assign ReadDataW   = r_readdata_w;
  assign ALUOutW     = r_aluout_w;
  assign WriteRegW   = r_writereg_w;
  assign timeout_err = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized self-checking bench for mem_wb_stage against a transaction-level model.
`default_nettype none

module tb_mem_wb_stage;

  localparam int TB_MAX_WAIT = 4;

  logic        clk;
  logic        rst_n;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        StallM;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;
  logic        timeout_err;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_checks;
  int n_fail;

  mem_wb_stage #(
    .WAIT_W   (8),
    .MAX_WAIT (TB_MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RegWriteM   (RegWriteM),
    .MemtoRegM   (MemtoRegM),
    .MemWriteM   (MemWriteM),
    .ALUOutM     (ALUOutM),
    .WriteDataM  (WriteDataM),
    .WriteRegM   (WriteRegM),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .StallM      (StallM),
    .RegWriteW   (RegWriteW),
    .MemtoRegW   (MemtoRegW),
    .ReadDataW   (ReadDataW),
    .ALUOutW     (ALUOutW),
    .WriteRegW   (WriteRegW),
    .timeout_err (timeout_err)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction through the M stage. The access is acknowledged in request
  // cycle ackdly (0 = same cycle); the model says it completes if ackdly <= MAX_WAIT,
  // otherwise it is aborted after MAX_WAIT stall cycles.
  task automatic do_access(input logic rw, input logic mtr, input logic mw,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] wr, input int ackdly,
                           input logic [31:0] rd, input bit scramble, input string tag);
    logic memop;
    logic exp_stall;
    memop      = mw | mtr;
    RegWriteM  = rw;
    MemtoRegM  = mtr;
    MemWriteM  = mw;
    ALUOutM    = alu;
    WriteDataM = wd;
    WriteRegM  = wr;
    if (!memop) begin
      dmem_ack   = 1'($urandom);
      dmem_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if ({dmem_req, StallM} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s nomem_req_stall: got %b expected 00", tag, {dmem_req, StallM});
      end
      @(posedge clk); #1;
      n_checks++;
      if ({RegWriteW, MemtoRegW, ALUOutW, WriteRegW, ReadDataW, timeout_err} !==
          {rw, mtr, alu, wr, 32'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s nomem_W: got rw=%b mtr=%b alu=%h wr=%0d rd=%h to=%b expected rw=%b mtr=%b alu=%h wr=%0d rd=0 to=0",
                 tag, RegWriteW, MemtoRegW, ALUOutW, WriteRegW, ReadDataW, timeout_err, rw, mtr, alu, wr);
      end
      dmem_ack = 1'b0;
      return;
    end
    for (int idx = 0; idx <= TB_MAX_WAIT; idx++) begin
      if (idx > 0 && scramble) begin
        RegWriteM  = 1'($urandom);
        MemtoRegM  = 1'($urandom);
        MemWriteM  = 1'($urandom);
        ALUOutM    = $urandom;
        WriteDataM = $urandom;
        WriteRegM  = 5'($urandom);
      end
      dmem_ack   = (idx == ackdly);
      dmem_rdata = (idx == ackdly) ? rd : $urandom;
      exp_stall  = !(idx == ackdly || idx == TB_MAX_WAIT);
      @(negedge clk);
      n_checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, StallM} !== {1'b1, mw, alu, wd, exp_stall}) begin
        n_fail++;
        $display("FAIL %s port[%0d]: got req=%b we=%b addr=%h wdata=%h stall=%b expected req=1 we=%b addr=%h wdata=%h stall=%b",
                 tag, idx, dmem_req, dmem_we, dmem_addr, dmem_wdata, StallM, mw, alu, wd, exp_stall);
      end
      @(posedge clk); #1;
      if (idx == ackdly) begin
        n_checks++;
        if ({RegWriteW, MemtoRegW, ALUOutW, WriteRegW, ReadDataW, timeout_err} !==
            {rw & ~mw, mtr, alu, wr, (mw ? 32'd0 : rd), 1'b0}) begin
          n_fail++;
          $display("FAIL %s done_W: got rw=%b mtr=%b alu=%h wr=%0d rd=%h to=%b expected rw=%b mtr=%b alu=%h wr=%0d rd=%h to=0",
                   tag, RegWriteW, MemtoRegW, ALUOutW, WriteRegW, ReadDataW, timeout_err,
                   rw & ~mw, mtr, alu, wr, (mw ? 32'd0 : rd));
        end
        break;
      end else if (idx == TB_MAX_WAIT) begin
        n_checks++;
        if ({RegWriteW, MemtoRegW, timeout_err} !== 3'b001) begin
          n_fail++;
          $display("FAIL %s timeout_W: got rw=%b mtr=%b to=%b expected rw=0 mtr=0 to=1",
                   tag, RegWriteW, MemtoRegW, timeout_err);
        end
      end else begin
        n_checks++;
        if ({RegWriteW, MemtoRegW, timeout_err} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s stall_bubble[%0d]: got rw=%b mtr=%b to=%b expected 000",
                   tag, idx, RegWriteW, MemtoRegW, timeout_err);
        end
      end
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    n_checks++;
    if ({dmem_req, StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b stall=%b rw=%b mtr=%b rd=%h alu=%h wr=%0d to=%b expected all 0",
               dmem_req, StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait_load();
    do_access(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd8, 0, 32'hDEAD_BEEF, 1'b0, "zero_wait_load");
  endtask

  task automatic test_store_wait();
    do_access(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5'd4, 3, 32'hFFFF_0000, 1'b0, "store_wait3");
  endtask

  task automatic test_alu();
    for (int i = 0; i < 3; i++)
      do_access(1'b1, 1'b0, 1'b0, 32'h0000_0055, $urandom, 5'd3, 0, 32'h0, 1'b0, "alu_op");
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd9, 99, 32'h0, 1'b0, "timeout_load");
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd2, 0, 32'h0, 1'b0, "after_timeout");
  endtask

  task automatic test_reset_during_wait();
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    ALUOutM = 32'h0000_0080; WriteDataM = '0; WriteRegM = 5'd12;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({dmem_req, StallM} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_wait_pre: got req=%b stall=%b expected 11", dmem_req, StallM);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dmem_req, StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_async: got req=%b stall=%b rw=%b mtr=%b rd=%h alu=%h wr=%0d to=%b expected all 0",
               dmem_req, StallM, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, timeout_err);
    end
    RegWriteM = 1'b0; MemtoRegM = 1'b0; ALUOutM = '0; WriteRegM = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    #1;
    n_checks++;
    if ({dmem_req, StallM} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_late_ack_port: got req=%b stall=%b expected 00", dmem_req, StallM);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL rst_late_ack_W: got rw=%b mtr=%b rd=%h alu=%h wr=%0d to=%b expected all 0",
               RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, timeout_err);
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_access(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 5'(i + 16), 0, $urandom, 1'b0, "b2b_load");
  endtask

  task automatic test_random();
    logic        mtr, mw, rw;
    logic [31:0] alu;
    int          kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      rw   = 1'($urandom);
      mtr  = (kind == 1);
      mw   = (kind == 2);
      alu  = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      alu[1:0] = 2'b00;
`endif
      do_access(rw, mtr, mw, alu, $urandom, 5'($urandom), $urandom_range(0, TB_MAX_WAIT + 2),
                $urandom, 1'b1, "random");
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    ALUOutM = 32'h0000_0013; WriteDataM = '0; WriteRegM = 5'd7;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dmem_req, StallM} !== 2'b00) begin
      n_fail++;
      $display("FAIL misalign_port: got req=%b stall=%b expected 00", dmem_req, StallM);
    end
    @(posedge clk); #1;
    RegWriteM = 1'b0; MemtoRegM = 1'b0; ALUOutM = '0;
    n_checks++;
    if ({RegWriteW, misalign_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL misalign_pulse: got rw=%b err=%b expected rw=0 err=1", RegWriteW, misalign_err);
    end
    @(posedge clk); #1;
    n_checks++;
    if (misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_clear: got err=%b expected 0", misalign_err);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_alu();
    test_timeout();
    test_reset_during_wait();
    test_back_to_back();
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
